// File: rtl/hdmi_qsys_timer_sequencer.sv
// Programs an Avalon interval-timer slave, services its timeouts and divides
// them down into frame_tick pulses with a running frame_count.
module hdmi_qsys_timer_sequencer #(
  parameter int unsigned DEFAULT_PERIOD = 50000,
  parameter int unsigned TICK_DIV       = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] cfg_period,
  input  logic        cfg_valid,
  input  logic        tmr_irq,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  output logic        frame_tick,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam logic [7:0]  LP_TICK_DIV = 8'(TICK_DIV);
  localparam logic [31:0] LP_DEF_PER  = 32'(DEFAULT_PERIOD);

  typedef enum logic [3:0] {
    IDLE, W_STOP, W_CLR, W_PERL, W_PERH, W_START, RUN, W_ACK, ACK_GAP
  } state_t;

  state_t      r_state, w_next;
  logic        r_stopping, w_stopping_nxt;
  logic [31:0] r_period;
  logic [31:0] w_pv;
  logic [7:0]  r_div;
  logic [7:0]  w_div_inc;
  logic        w_tick_nxt;
  logic        r_frame_tick;
  logic [15:0] r_frame_count;
  logic        r_busy;

  assign w_pv       = (r_period < 32'd2) ? 32'd1 : r_period - 32'd1;
  assign w_div_inc  = r_div + 8'd1;
  assign w_tick_nxt = (r_state == W_ACK) && (w_div_inc == LP_TICK_DIV);

  // A stop request first finishes the current write, then replays STOP/CLR
  // under r_stopping and parks in IDLE; cfg_valid only latches meanwhile.
  always_comb begin
    w_next         = r_state;
    w_stopping_nxt = r_stopping;
    if (r_state != IDLE && !enable && !r_stopping) begin
      w_next         = W_STOP;
      w_stopping_nxt = 1'b1;
    end else if (r_stopping) begin
      if (r_state == W_STOP) begin
        w_next = W_CLR;
      end else begin
        w_next         = IDLE;
        w_stopping_nxt = 1'b0;
      end
    end else begin
      case (r_state)
        IDLE:    w_next = enable ? W_STOP : IDLE;
        W_STOP:  w_next = cfg_valid ? W_STOP : W_CLR;
        W_CLR:   w_next = cfg_valid ? W_STOP : W_PERL;
        W_PERL:  w_next = cfg_valid ? W_STOP : W_PERH;
        W_PERH:  w_next = cfg_valid ? W_STOP : W_START;
        W_START: w_next = cfg_valid ? W_STOP : RUN;
        RUN: begin
          if (cfg_valid)    w_next = W_STOP;
          else if (tmr_irq) w_next = W_ACK;
          else              w_next = RUN;
        end
        W_ACK:   w_next = cfg_valid ? W_STOP : ACK_GAP;
        ACK_GAP: w_next = cfg_valid ? W_STOP : RUN;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = '0;
    tmr_writedata  = '0;
    case (r_state)
      W_STOP: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = 3'd1; tmr_writedata = 16'h0008;
      end
      W_CLR, W_ACK: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
      end
      W_PERL: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = 3'd2; tmr_writedata = w_pv[15:0];
      end
      W_PERH: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = 3'd3; tmr_writedata = w_pv[31:16];
      end
      W_START: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = 3'd1; tmr_writedata = 16'h0007;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_stopping    <= 1'b0;
      r_period      <= LP_DEF_PER;
      r_div         <= '0;
      r_frame_tick  <= 1'b0;
      r_frame_count <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_stopping    <= w_stopping_nxt;
      r_busy        <= (w_next != IDLE) && (w_next != RUN);
      r_frame_tick  <= w_tick_nxt;
      r_frame_count <= r_frame_count + {15'd0, w_tick_nxt};
      if (cfg_valid) r_period <= cfg_period;
      if (r_state == W_STOP)     r_div <= '0;
      else if (r_state == W_ACK) r_div <= w_tick_nxt ? '0 : w_div_inc;
    end
  end

  assign frame_tick  = r_frame_tick;
  assign frame_count = r_frame_count;
  assign busy        = r_busy;

endmodule

// File: tb/tb_hdmi_qsys_timer_sequencer.sv
// Directed table-driven bench for hdmi_qsys_timer_sequencer (TICK_DIV=3).
module tb_hdmi_qsys_timer_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] cfg_period;
  logic        cfg_valid;
  logic        tmr_irq;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        frame_tick;
  logic [15:0] frame_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  hdmi_qsys_timer_sequencer #(.DEFAULT_PERIOD(50000), .TICK_DIV(3)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_period(cfg_period),
    .cfg_valid(cfg_valid), .tmr_irq(tmr_irq), .tmr_address(tmr_address),
    .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .frame_tick(frame_tick),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        cv;
    logic [31:0] cp;
    logic        irq;
    logic        cs;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        busy;
    logic        tick;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void wr(input logic en, input logic cv, input logic [31:0] cp,
                             input logic irq, input logic [2:0] a, input logic [15:0] d,
                             input logic [15:0] c);
    vec_t v;
    v = '{en, cv, cp, irq, 1'b1, a, d, 1'b1, 1'b0, c};
    tbl.push_back(v);
  endfunction

  function automatic void nw(input logic en, input logic cv, input logic [31:0] cp,
                             input logic irq, input logic b, input logic t,
                             input logic [15:0] c);
    vec_t v;
    v = '{en, cv, cp, irq, 1'b0, 3'd0, 16'h0000, b, t, c};
    tbl.push_back(v);
  endfunction

  // Full programming sequence; the first row's inputs start it.
  function automatic void prog(input logic cv, input logic [31:0] cp, input logic irq,
                               input logic [15:0] lo, input logic [15:0] hi,
                               input logic [15:0] c);
    wr(1, cv, cp, irq, 3'd1, 16'h0008, c);
    wr(1, 0, 0, 0, 3'd0, 16'h0000, c);
    wr(1, 0, 0, 0, 3'd2, lo, c);
    wr(1, 0, 0, 0, 3'd3, hi, c);
    wr(1, 0, 0, 0, 3'd1, 16'h0007, c);
    nw(1, 0, 0, 0, 1'b0, 1'b0, c);
  endfunction

  // One timeout service from RUN: W_ACK, ACK_GAP, RUN.
  function automatic void svc(input logic gap_irq, input logic t, input logic [15:0] c_before);
    logic [15:0] c_after;
    c_after = t ? c_before + 16'd1 : c_before;
    wr(1, 0, 0, 1, 3'd0, 16'h0000, c_before);
    nw(1, 0, 0, gap_irq, 1'b1, t, c_after);
    nw(1, 0, 0, 0, 1'b0, 1'b0, c_after);
  endfunction

  task automatic chk(input string name, input logic cs, input logic [2:0] a,
                     input logic [15:0] d, input logic b, input logic t,
                     input logic [15:0] c);
    checks++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, busy, frame_tick, frame_count}
        !== {cs, ~cs, a, d, b, t, c}) begin
      errors++;
      $display("FAIL %s: got cs=%b wn=%b addr=%0d data=%h busy=%b tick=%b cnt=%h, expected cs=%b wn=%b addr=%0d data=%h busy=%b tick=%b cnt=%h",
               name, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, busy,
               frame_tick, frame_count, cs, ~cs, a, d, b, t, c);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    enable = v.en; cfg_valid = v.cv; cfg_period = v.cp; tmr_irq = v.irq;
    @(posedge clk);
    @(negedge clk);
    chk(name, v.cs, v.addr, v.data, v.busy, v.tick, v.cnt);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; cfg_valid = 1'b0; cfg_period = '0; tmr_irq = 1'b0;

    // Startup with default period 50000 -> pv 0xC34F
    prog(0, 0, 0, 16'hC34F, 16'h0000, 16'd0);
    // Three services give one tick; irq held through the first ACK_GAP is ignored
    svc(1, 0, 16'd0);
    svc(0, 0, 16'd0);
    svc(0, 1, 16'd0);
    svc(0, 0, 16'd1);
    // Reprogram to 0x10000 mid-count: divider restarts, tick after three more
    prog(1, 32'h0001_0000, 0, 16'hFFFF, 16'h0000, 16'd1);
    svc(0, 0, 16'd1);
    svc(0, 0, 16'd1);
    svc(0, 1, 16'd1);
    // cfg_valid and irq together in RUN: reprogram wins, no ack
    prog(1, 32'h0001_0000, 1, 16'hFFFF, 16'h0000, 16'd2);
    // Clamp: period 0 -> pv 1
    prog(1, 32'd0, 0, 16'h0001, 16'h0000, 16'd2);
    // cfg_valid during W_CLR: write completes, restart with latest period
    wr(1, 1, 32'd5, 0, 3'd1, 16'h0008, 16'd2);
    wr(1, 0, 0, 0, 3'd0, 16'h0000, 16'd2);
    prog(1, 32'd6, 0, 16'h0005, 16'h0000, 16'd2);
    // enable drops during W_PERL together with a new period
    wr(1, 1, 32'd100, 0, 3'd1, 16'h0008, 16'd2);
    wr(1, 0, 0, 0, 3'd0, 16'h0000, 16'd2);
    wr(1, 0, 0, 0, 3'd2, 16'h0063, 16'd2);
    wr(0, 1, 32'd200, 0, 3'd1, 16'h0008, 16'd2);
    wr(0, 0, 0, 0, 3'd0, 16'h0000, 16'd2);
    nw(0, 0, 0, 0, 1'b0, 1'b0, 16'd2);
    nw(0, 0, 0, 0, 1'b0, 1'b0, 16'd2);
    prog(0, 0, 0, 16'h00C7, 16'h0000, 16'd2);

    @(negedge clk);
    @(negedge clk);
    chk("reset_state", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

    // Wrap: preload frame_count to 0xFFFF, then produce one tick
    tbl.delete();
    force dut.r_frame_count = 16'hFFFF;
    nw(1, 0, 0, 0, 1'b0, 1'b0, 16'hFFFF);
    apply(tbl[0], "preload_forced");
    release dut.r_frame_count;
    apply(tbl[0], "preload_held");
    tbl.delete();
    svc(0, 0, 16'hFFFF);
    svc(0, 0, 16'hFFFF);
    svc(0, 1, 16'hFFFF);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("wrap%0d", i));

    // Reset in W_PERH: outputs clear at once, sequence restarts cleanly
    tbl.delete();
    wr(1, 1, 32'd100, 0, 3'd1, 16'h0008, 16'd0);
    wr(1, 0, 0, 0, 3'd0, 16'h0000, 16'd0);
    wr(1, 0, 0, 0, 3'd2, 16'h0063, 16'd0);
    wr(1, 0, 0, 0, 3'd3, 16'h0000, 16'd0);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("rst_seq%0d", i));
    #2 reset_n = 1'b0;
    #1 chk("reset_async", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    chk("reset_held", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    reset_n = 1'b1;
    tbl.delete();
    prog(0, 0, 0, 16'hC34F, 16'h0000, 16'd0);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("restart%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
